// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency sprite ROM among NUM_REQ requesters.
// Optional build macro SPRITE_ARB_CONFLICT_CNT_EN adds a saturating multi-request counter.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_data,
    output logic                        rd_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rd_id,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_REQ*DATA_W-1:0]   hold_data
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]                 conflict_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic              pv;
    logic [ID_W-1:0]   pid;
    logic              found;
    logic [ID_W-1:0]   win;
    logic [DATA_W-1:0] hold_q [NUM_REQ];

    // First set request at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        gnt      = '0;
        rom_addr = '0;
        if (found) begin
            gnt[win] = 1'b1;
            rom_addr = req_addr[win*ADDR_W +: ADDR_W];
        end
    end

    assign ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= '0;
            pv  <= 1'b0;
            pid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            pv <= found;
            if (found) begin
                ptr <= ptr_nxt;
                pid <= win;
            end
            if (pv) begin
                hold_q[pid] <= rom_data;
            end
        end
    end

    assign rd_valid = pv;
    assign rd_id    = pid;
    assign rd_data  = pv ? rom_data : '0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
        assign hold_data[g*DATA_W +: DATA_W] = hold_q[g];
    end

`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    logic multi;

    // Two or more bits set exactly when clearing the lowest set bit leaves something.
    assign multi = |(req & (req - 1'b1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            conflict_cnt <= '0;
        end else if (multi && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table plus randomized run against a reference model.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;

    logic              Clk;
    logic              Reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      gnt;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic              rd_valid;
    logic [1:0]        rd_id;
    logic [DW-1:0]     rd_data;
    logic [N*DW-1:0]   hold_data;
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
    logic [15:0]       conflict_cnt;
`endif

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .req(req),
        .req_addr(req_addr),
        .gnt(gnt),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .rd_valid(rd_valid),
        .rd_id(rd_id),
        .rd_data(rd_data),
        .hold_data(hold_data)
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [DW-1:0] mem [512];
    always @(posedge Clk) rom_data <= mem[rom_addr];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_ptr;
    logic          m_pv;
    int            m_pid;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_hold [N];
    int            m_cc;

    typedef struct {
        logic       rst;
        logic [3:0] rq;
        logic [3:0] e_gnt;
        logic       e_v;
        logic [1:0] e_id;
        logic [7:0] e_d;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_pv = 1'b0; m_pid = 0; m_paddr = '0; m_cc = 0;
        for (int i = 0; i < N; i++) m_hold[i] = '0;
    endtask

    task automatic step(input logic rst, input logic [3:0] r, input logic [N*AW-1:0] a,
                        input logic has_exp, input vec_t ev);
        int best;
        int bestd;
        int d;
        int nb;
        logic [3:0]    eg;
        logic [AW-1:0] ea;
        @(negedge Clk);
        Reset = rst; req = r; req_addr = a;
        #1;
        best = -1; bestd = N; nb = 0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                nb++;
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        eg = '0; ea = '0;
        if (best >= 0) begin eg[best] = 1'b1; ea = a[best*AW +: AW]; end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        chk("rd_valid", 32'(rd_valid), 32'(m_pv));
        chk("rd_id", 32'(rd_id), 32'(m_pid));
        chk("rd_data", 32'(rd_data), m_pv ? 32'(mem[m_paddr]) : 32'd0);
        for (int i = 0; i < N; i++) chk("hold_data", 32'(hold_data[i*DW +: DW]), 32'(m_hold[i]));
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cc));
`endif
        if (has_exp) begin
            chk("tbl_gnt", 32'(gnt), 32'(ev.e_gnt));
            chk("tbl_valid", 32'(rd_valid), 32'(ev.e_v));
            chk("tbl_id", 32'(rd_id), 32'(ev.e_id));
            chk("tbl_data", 32'(rd_data), 32'(ev.e_d));
        end
        @(posedge Clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_pv) m_hold[m_pid] = mem[m_paddr];
            if (best >= 0) begin
                m_ptr = (best + 1) % N; m_pv = 1'b1; m_pid = best; m_paddr = ea;
            end else begin
                m_pv = 1'b0;
            end
            if (nb >= 2 && m_cc < 65535) m_cc++;
        end
    endtask

    initial begin
        logic [N*AW-1:0] ta;
        logic [N*AW-1:0] ra;
        vec_t none;
        none = '{1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 8'h00};

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[10] = 8'h11; mem[20] = 8'h22; mem[37] = 8'h5A; mem[50] = 8'h77;

        ta = {9'd50, 9'd37, 9'd20, 9'd10};

        //            rst   req      gnt      v     id    data
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0, 8'h00};
        tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h5A};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 8'h5A};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'h5A};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'h00};
        tbl[8]  = '{1'b0, 4'b0101, 4'b0001, 1'b0, 2'd2, 8'h00};
        tbl[9]  = '{1'b0, 4'b0101, 4'b0100, 1'b1, 2'd0, 8'h11};
        tbl[10] = '{1'b0, 4'b0101, 4'b0001, 1'b1, 2'd2, 8'h5A};
        tbl[11] = '{1'b1, 4'b0101, 4'b0100, 1'b1, 2'd0, 8'h11};
        tbl[12] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 2'd0, 8'h00};
        tbl[13] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd0, 8'h11};
        tbl[14] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd1, 8'h22};
        tbl[15] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd2, 8'h5A};
        tbl[16] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd3, 8'h77};
        tbl[17] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd0, 8'h11};
        tbl[18] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd1, 8'h22};
        tbl[19] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd2, 8'h5A};
        tbl[20] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 2'd3, 8'h77};
        tbl[21] = '{1'b0, 4'b0011, 4'b0001, 1'b0, 2'd0, 8'h00};
        tbl[22] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h11};
        tbl[23] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[24] = '{1'b0, 4'b0011, 4'b0010, 1'b0, 2'd0, 8'h00};
        tbl[25] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 2'd1, 8'h22};
        tbl[26] = '{1'b0, 4'b0011, 4'b0010, 1'b1, 2'd0, 8'h11};
        tbl[27] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 2'd1, 8'h22};

        Reset = 1'b1; req = '0; req_addr = '0;
        repeat (2) @(posedge Clk);
        model_reset();

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].rst, tbl[i].rq, ta, 1'b1, tbl[i]);
`ifdef SPRITE_ARB_CONFLICT_CNT_EN
            if (i == 19) begin
                #1;
                chk("conflict_cnt_after_rr", 32'(conflict_cnt), 32'd8);
            end
`endif
        end

        // Alternating losers: both hold entries carry their own last pixel.
        #1;
        chk("loser_hold0", 32'(hold_data[0 +: DW]), 32'h11);
        chk("loser_hold1", 32'(hold_data[DW +: DW]), 32'h22);
        chk("loser_hold2", 32'(hold_data[2*DW +: DW]), 32'h00);
        chk("loser_hold3", 32'(hold_data[3*DW +: DW]), 32'h00);

        // Single requester held continuously keeps winning.
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1000, ta, 1'b0, none);

        for (int i = 0; i < 600; i++) begin
            ra = {4{9'($urandom)}};
            for (int j = 0; j < N; j++) ra[j*AW +: AW] = 9'($urandom);
            step($urandom_range(0, 31) == 0, 4'($urandom_range(0, 15)), ra, 1'b0, none);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one synchronous-read sprite ROM (e.g. `gemROM`, 1-cycle latency) among up to `NUM_REQ` sprite instances. Round-robin arbitration runs per pixel clock. Returned data is tagged with the winner's ID and also latched into a per-requester hold register, so a requester that loses arbitration can redraw its last fetched pixel. It sits between the per-object sprite logic and the shared ROM inside a sprite controller such as the score/gem controller.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 9: ROM address width.
- `DATA_W`, default 8: ROM data width.

Ports:
- `Clk`, input, 1: system clock. The block uses one clock.
- `Reset`, input, 1: reset, synchronous and active-high.
- `req`, input, `NUM_REQ`: request per requester. Bit i set means requester i is drawing this cycle.
- `req_addr`, input, `NUM_REQ`×`ADDR_W`: read address per requester.
- `gnt`, output, `NUM_REQ`: one-hot grant, combinational in the same cycle as `req`.
- `rom_addr`, output, `ADDR_W`: address driven to the ROM.
- `rom_data`, input, `DATA_W`: ROM read data, valid one cycle after `rom_addr`.
- `rd_valid`, output, 1: `rom_data` in this cycle answers a grant from the previous cycle.
- `rd_id`, output, $clog2(`NUM_REQ`): requester index that owns the current `rom_data`.
- `rd_data`, output, `DATA_W`: equals `rom_data` when `rd_valid` is 1, else 0.
- `hold_data`, output, `NUM_REQ`×`DATA_W`: last data returned to each requester.
- `conflict_cnt`, output, 16: present only when `SPRITE_ARB_CONFLICT_CNT_EN` is defined.

## Operation
- State: round-robin pointer `ptr` (0..`NUM_REQ`-1), pending-valid flag `pv`, pending ID `pid`, `hold_data` registers.
- Arbitration: the winner is the first set `req` bit found by scanning from index `ptr` upward, wrapping modulo `NUM_REQ`.
- With a winner w:
  - `gnt` = 1<<w.
  - `rom_addr` = `req_addr[w]`.
  - Next `ptr` = (w+1) mod `NUM_REQ`. With `NUM_REQ`-1 the pointer wraps to 0.
  - Next `pv` = 1 and next `pid` = w.
- With no request:
  - `gnt` = 0 and `rom_addr` = 0.
  - `ptr` is unchanged and next `pv` = 0.
- Return: `rd_valid` = `pv`, `rd_id` = `pid`.
- Hold update: on every cycle with `pv`=1, `hold_data[pid]` <= `rom_data`. All other hold entries keep their value.
- A single requester that asserts continuously wins every cycle.
- Simultaneous requests: exactly one bit of `gnt` is set. Losers receive nothing new and use `hold_data`.
- Out-of-range `req_addr` is passed through unchanged. The requester owns its bounds.

## Timing
- Grant latency: 0 cycles (combinational from `req`/`ptr`).
- Data latency: 1 cycle. A grant in cycle T gives `rd_valid`/`rd_id`/`rd_data` in T+1 and an updated `hold_data` visible in T+2.
- The block sustains one grant per cycle with back-to-back grants and no bubbles.
- Reset values:
  - `ptr`=0, `pv`=0, `pid`=0, every `hold_data` entry 0, `conflict_cnt`=0.
  - Consequently `rd_valid`=0, `rd_id`=0, `rd_data`=0.
- Reset during operation:
  - Reset asserted at the edge ending cycle T discards the cycle-T grant. `rd_valid` is 0 in T+1 and no hold update occurs.
  - While `Reset` is high, `gnt` and `rom_addr` still follow the combinational rule, but no state advances.

## Configuration
- `SPRITE_ARB_CONFLICT_CNT_EN` defined:
  - The `conflict_cnt` port exists.
  - It increments by 1 on every non-reset cycle in which two or more `req` bits are set.
  - It saturates at 16'hFFFF and clears on `Reset`.
- Not defined: the port and its counter are removed entirely. All other behaviour is identical.

## Test plan
- Reset, then idle: `Reset`=1 for 2 cycles, then `req`=0 for 3 cycles. Required: `gnt`=0, `rom_addr`=0, `rd_valid`=0, `hold_data` all 0.
- Single requester: `req`=4'b0100 with addr 9'd37 for 3 cycles, ROM preloaded with mem[37]=8'h5A. Required:
  - `gnt`=4'b0100 every cycle.
  - From the second cycle on, `rd_valid`=1, `rd_id`=2, `rd_data`=8'h5A.
  - `hold_data[2]`=8'h5A.
- Round-robin fairness: `req`=4'b1111 for 8 cycles from reset. Required:
  - `gnt` sequence 0001, 0010, 0100, 1000, 0001, ….
  - `rd_id` sequence 0,1,2,3,0,… lagging by one cycle.
  - `conflict_cnt`=8 with the macro defined.
- Wrap and skip: `ptr`=3 (after granting 2), `req`=4'b0101. Required: grant to 0, then grant to 2, then grant to 0.
- Loser hold: requesters 0 and 1 both request every cycle with addrs 10 and 20, mem[10]=8'h11, mem[20]=8'h22. Required:
  - `hold_data[0]`=8'h11 and `hold_data[1]`=8'h22, stable.
  - Each entry updates every other cycle.
- Reset mid-fetch: grant to requester 1 in cycle T and assert `Reset` in T. Required:
  - `rd_valid`=0 in T+1.
  - `hold_data[1]` stays 0.
  - The next grant after release goes to the lowest set request, since `ptr`=0.
